// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by both the transmit and receive stages.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int   CLKS_PER_BIT_DEF = 400;
  localparam int   DATA_BITS        = 8;
  localparam logic LINE_IDLE        = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single
// asynchronous bit, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to settle metastability.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at
// mid-bit, centre sampling, valid/error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  logic                 sync_w;
  logic                 prev_q;
  logic                 fall_w;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;
  logic                 ferr_q;

  sync_2ff #(
    .RST_VAL (LINE_IDLE)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (bit_in),
    .q_o   (sync_w)
  );

  // Delayed copy of the synced line for edge detect.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_q <= LINE_IDLE;
    end else begin
      prev_q <= sync_w;
    end
  end

  assign fall_w = prev_q & ~sync_w;

  // Frame FSM: bit timing, shifting, strobes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (fall_w) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (sync_w == LINE_IDLE) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync_w,
                        shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (sync_w == LINE_IDLE) begin
              dout_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, glitch,
// framing error, mid-frame reset and line break.
module tb_uart_rx;

  localparam int CPB = 400;

  logic       sys_clk;
  logic       sys_rst;
  logic       bit_in;
  logic [7:0] dout;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks;
  int errors;

  int cyc;
  int nvalid;
  int nferr;
  int nboth;
  int last_valid_cyc;
  int fall_cyc;
  logic [7:0] last_dout;
  logic [7:0] rxq[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .bit_in     (bit_in),
    .dout       (dout),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (data_valid === 1'b1) begin
      nvalid = nvalid + 1;
      last_dout = dout;
      last_valid_cyc = cyc;
      rxq.push_back(dout);
    end
    if (frame_err === 1'b1) nferr = nferr + 1;
    if (data_valid === 1'b1 && frame_err === 1'b1)
      nboth = nboth + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop_v);
    bit_in = 1'b0;
    fall_cyc = cyc;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      bit_in = b[i];
      wait_cyc(CPB);
    end
    bit_in = stop_v;
    wait_cyc(CPB);
    bit_in = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    bit_in  = 1'b1;
    wait_cyc(3);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h want 00", dout);
    end
    checks++;
    if ({data_valid, frame_err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {data_valid, frame_err, busy});
    end
    sys_rst = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_single();
    int v0, f0, lat;
    v0 = nvalid;
    f0 = nferr;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(CPB * 9 + CPB / 4);
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_mid: got %b want 1",
                   busy);
        end
      end
    join
    wait_cyc(10);
    checks++;
    if (nvalid - v0 != 1) begin
      errors++;
      $display("FAIL single_nvalid: got %0d want 1",
               nvalid - v0);
    end
    checks++;
    if (last_dout !== 8'hA5) begin
      errors++;
      $display("FAIL single_dout: got %h want a5",
               last_dout);
    end
    checks++;
    if (nferr - f0 != 0) begin
      errors++;
      $display("FAIL single_ferr: got %0d want 0",
               nferr - f0);
    end
    lat = last_valid_cyc - fall_cyc;
    checks++;
    if (lat < 3800 || lat > 3806) begin
      errors++;
      $display("FAIL single_latency: got %0d want 3800..3806",
               lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = nvalid;
    f0 = nferr;
    send_frame(8'h3C, 1'b0);
    wait_cyc(2 * CPB);
    checks++;
    if (nferr - f0 != 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d want 1",
               nferr - f0);
    end
    checks++;
    if (nvalid - v0 != 0) begin
      errors++;
      $display("FAIL ferr_nvalid: got %0d want 0",
               nvalid - v0);
    end
    checks++;
    if (dout !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_dout: got %h want a5", dout);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    logic [7:0] exp [3];
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h81;
    f0 = nferr;
    rxq.delete();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    wait_cyc(10);
    checks++;
    if (rxq.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 3",
               rxq.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < rxq.size()) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b_byte%0d: got %h want %h",
                   i, rxq[i], exp[i]);
        end
      end
    end
    checks++;
    if (nferr - f0 != 0) begin
      errors++;
      $display("FAIL b2b_ferr: got %0d want 0",
               nferr - f0);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = nvalid;
    f0 = nferr;
    bit_in = 1'b0;
    wait_cyc(50);
    bit_in = 1'b1;
    wait_cyc(100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi: got %b want 1", busy);
    end
    wait_cyc(100);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo: got %b want 0", busy);
    end
    wait_cyc(CPB * 11);
    checks++;
    if (nvalid - v0 != 0 || nferr - f0 != 0) begin
      errors++;
      $display("FAIL glitch_strobes: got v=%0d e=%0d want 0 0",
               nvalid - v0, nferr - f0);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] b;
    b = 8'h5A;
    bit_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      bit_in = b[i];
      wait_cyc(CPB);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy_pre: got %b want 1", busy);
    end
    v0 = nvalid;
    f0 = nferr;
    sys_rst = 1'b1;
    bit_in  = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL rmid_async: got busy=%b dout=%h want 0 00",
               busy, dout);
    end
    wait_cyc(3);
    sys_rst = 1'b0;
    wait_cyc(CPB * 12);
    checks++;
    if (nvalid - v0 != 0 || nferr - f0 != 0) begin
      errors++;
      $display("FAIL rmid_strobes: got v=%0d e=%0d want 0 0",
               nvalid - v0, nferr - f0);
    end
    checks++;
    if (busy !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL rmid_idle: got busy=%b dout=%h want 0 00",
               busy, dout);
    end
    send_frame(8'h5A, 1'b1);
    wait_cyc(10);
    checks++;
    if (nvalid - v0 != 1 || last_dout !== 8'h5A) begin
      errors++;
      $display("FAIL rmid_next: got n=%0d dout=%h want 1 5a",
               nvalid - v0, last_dout);
    end
  endtask

  task automatic test_break();
    int v0, f0;
    v0 = nvalid;
    f0 = nferr;
    bit_in = 1'b0;
    wait_cyc(20 * CPB);
    checks++;
    if (nferr - f0 != 1) begin
      errors++;
      $display("FAIL break_ferr: got %0d want 1",
               nferr - f0);
    end
    checks++;
    if (busy !== 1'b0 || nvalid - v0 != 0) begin
      errors++;
      $display("FAIL break_idle: got busy=%b v=%0d want 0 0",
               busy, nvalid - v0);
    end
    bit_in = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(8'hC3, 1'b1);
    wait_cyc(10);
    checks++;
    if (nvalid - v0 != 1 || last_dout !== 8'hC3) begin
      errors++;
      $display("FAIL break_next: got n=%0d dout=%h want 1 c3",
               nvalid - v0, last_dout);
    end
    checks++;
    if (nferr - f0 != 1) begin
      errors++;
      $display("FAIL break_ferr_total: got %0d want 1",
               nferr - f0);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (nboth != 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d want 0", nboth);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    nvalid = 0;
    nferr = 0;
    nboth = 0;
    last_valid_cyc = 0;
    fall_cyc = 0;
    last_dout = 8'h00;
    sys_rst = 1'b1;
    bit_in = 1'b1;
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_break();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: it takes the line driven by the transmitter (8N1, LSB first, idle high) and recovers each byte. It synchronizes the asynchronous line, validates the start bit at mid-bit and samples every data and stop bit at its centre. It presents the byte with a one-cycle valid strobe, or flags a framing error. It sits directly downstream of the UART transmit stage, on the same 40 kHz system clock, at 400 clocks per bit.

## Interface
Parameters:
- CLKS_PER_BIT, 400: sys_clk cycles per bit. Must be even and ≥ 4.

Ports:
- sys_clk  in  1  system clock, 40 kHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  serial input line, asynchronous, idle high.
- dout  out  8  last correctly framed byte. Reset value 8'h00.
- data_valid  out  1  one-cycle pulse when dout updates. Reset value 0.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- busy  out  1  high while a frame is in progress (state ≠ IDLE). Reset value 0.

## Operation
- bit_in passes through a 2-flop synchronizer; both flops reset to 1.
- A third register holds the previous synchronized value, also reset to 1.
- Falling edge = previous is 1 and synchronized is 0. This edge is the only trigger for leaving IDLE.
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE. A cycle counter (cnt) and a bit index (idx, 0..7) drive the transitions.
- IDLE: cnt=0, idx=0. On a falling edge, go to START.
- START: cnt counts up to CLKS_PER_BIT/2−1, then the line is sampled.
  - Sample 0: go to DATA, cnt=0.
  - Sample 1: treat as a glitch and return to IDLE. No strobe.
- DATA: cnt counts 0..CLKS_PER_BIT−1. At CLKS_PER_BIT−1 the line is sampled into the shift register (shift right, new bit enters bit 7) and cnt returns to 0.
  - After the sample with idx=7, go to STOP; otherwise increment idx.
- STOP: cnt counts 0..CLKS_PER_BIT−1, then the line is sampled.
  - Sample 1: dout ← shift register, data_valid=1 for one cycle.
  - Sample 0: frame_err=1 for one cycle; dout holds its previous value.
  - Either way, go to IDLE on the same edge. The block is therefore re-armed at mid-stop-bit, so back-to-back frames are received.
- A line held low (break) produces one frame_err, then no further frames until the line returns high and falls again.
- Counter width is $clog2(CLKS_PER_BIT). cnt never wraps past CLKS_PER_BIT−1.
- data_valid and frame_err are never high in the same cycle.
- Reset mid-frame: all state and outputs return to reset values immediately. The partial frame is discarded, and the next falling edge starts a fresh frame.

## Timing
- Synchronizer plus edge detect: START is entered 3 sys_clk cycles after bit_in falls (±1, depending on the input phase).
- Start-bit sample: CLKS_PER_BIT/2 cycles after entering START.
- Data bit n (n = 0..7) sample: CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT cycles after entering START.
- data_valid / frame_err: registered, high on the cycle after the stop sample.
  - For CLKS_PER_BIT=400 this falls within 3800..3806 cycles after the bit_in falling edge.
- Inputs are sampled at bit centre, giving a margin of ±CLKS_PER_BIT/2 − 4 cycles of accumulated clock skew per frame.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - the default CLKS_PER_BIT (400);
  - DATA_BITS (8);
  - the line idle level constant (1).
  The transmit stage uses the same constants.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1.

## Test plan
- The transmit stage sends 0xA5 into bit_in → exactly one data_valid pulse with dout=0xA5, frame_err stays 0, busy falls after mid-stop-bit.
- Back-to-back transmit frames 0x00, then 0xFF, then 0x81 → three data_valid pulses with dout values in that order, and no frame_err.
- bit_in low for 50 cycles, then high → no data_valid or frame_err; busy is high about 200 cycles, then returns to 0.
- Hand-built frame 0x3C with the stop bit driven 0 → one frame_err pulse, no data_valid, dout unchanged (previous 0xA5).
- sys_rst pulsed after 3 data bits of 0x5A → busy=0, dout=0x00, no strobes; the next full frame 0x5A → data_valid with dout=0x5A.
- bit_in held low for 20 bit times, then released, then frame 0xC3 sent → exactly one frame_err during the break, then data_valid with dout=0xC3.
